// File: rtl/add_norm_round.sv
// add_norm_round: binary32 add/sub back end. It performs the effective add/subtract,
// normalizes with a leading-zero shift, rounds to nearest-even and packs the result.
module add_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_e,
    input  logic        in_sign,
    input  logic        in_sign_2,
    input  logic [26:0] in_m_1,
    input  logic [26:0] in_m_2,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_inf_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_of,
    output logic        out_uf
);
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [27:0] add_sum;
    logic        add_sign;
    always_comb begin
        add_sum  = '0;
        add_sign = in_sign;
        if (in_sign == in_sign_2) begin
            add_sum = {1'b0, in_m_1} + {1'b0, in_m_2};
        end else if (in_m_1 >= in_m_2) begin
            add_sum = {1'b0, in_m_1 - in_m_2};
        end else begin
            add_sum  = {1'b0, in_m_2 - in_m_1};
            add_sign = in_sign_2;
        end
        if (add_sum == '0) add_sign = 1'b0;
    end

    logic              s1_valid, s1_sign, s1_nan, s1_inf, s1_inf_sign;
    logic [27:0]       s1_sum;
    logic signed [9:0] s1_e;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_sum      <= '0;
            s1_e        <= '0;
        end else if (advance) begin
            s1_valid    <= in_valid;
            s1_sign     <= add_sign;
            s1_nan      <= in_nan;
            s1_inf      <= in_inf;
            s1_inf_sign <= in_inf_sign;
            s1_sum      <= add_sum;
            s1_e        <= signed'({2'b00, in_e});
        end
    end

    logic [4:0] lz;
    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 27; i++)
            if (s1_sum[i]) lz = 5'(26 - i);
    end

    // A zero sum leaves lz at 0, so it passes through unshifted and is recognised
    // downstream by the missing hidden bit.
    logic [26:0]       norm_m;
    logic signed [9:0] norm_e;
    always_comb begin
        norm_m = s1_sum[26:0] << lz;
        norm_e = s1_e - signed'({5'b0, lz});
        if (s1_sum[27]) begin
            norm_m = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
            norm_e = s1_e + 10'sd1;
        end
    end

    logic              s2_valid, s2_sign, s2_nan, s2_inf, s2_inf_sign;
    logic [26:0]       s2_m;
    logic signed [9:0] s2_e;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_m        <= '0;
            s2_e        <= '0;
        end else if (advance) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_nan      <= s1_nan;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
            s2_m        <= norm_m;
            s2_e        <= norm_e;
        end
    end

    // The hidden bit is always 1 for a non-zero value, so a carry out of the 23-bit
    // fraction is the same as a carry out of the full 24-bit mantissa.
    logic              rnd_up, rnd_carry;
    logic [22:0]       rnd_frac;
    logic signed [9:0] rnd_e;
    assign rnd_up = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
    assign {rnd_carry, rnd_frac} = {1'b0, s2_m[25:3]} + 24'(rnd_up);
    assign rnd_e = rnd_carry ? s2_e + 10'sd1 : s2_e;

    logic              s3_valid, s3_sign, s3_zero, s3_nan, s3_inf, s3_inf_sign;
    logic [22:0]       s3_frac;
    logic signed [9:0] s3_e;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid    <= 1'b0;
            s3_sign     <= 1'b0;
            s3_zero     <= 1'b0;
            s3_nan      <= 1'b0;
            s3_inf      <= 1'b0;
            s3_inf_sign <= 1'b0;
            s3_frac     <= '0;
            s3_e        <= '0;
        end else if (advance) begin
            s3_valid    <= s2_valid;
            s3_sign     <= s2_sign;
            s3_zero     <= !s2_m[26];
            s3_nan      <= s2_nan;
            s3_inf      <= s2_inf;
            s3_inf_sign <= s2_inf_sign;
            s3_frac     <= rnd_frac;
            s3_e        <= rnd_e;
        end
    end

    logic [31:0] pack_data;
    logic        pack_of, pack_uf;
    always_comb begin
        pack_data = {s3_sign, s3_e[7:0], s3_frac};
        pack_of   = 1'b0;
        pack_uf   = 1'b0;
        if (s3_nan) begin
            pack_data = 32'h7FC0_0000;
        end else if (s3_inf) begin
            pack_data = {s3_inf_sign, 31'h7F80_0000};
        end else if (s3_zero) begin
            pack_data = '0;
        end else if (s3_e >= 10'sd255) begin
            pack_data = {s3_sign, 31'h7F80_0000};
            pack_of   = 1'b1;
        end else if (s3_e <= 10'sd0) begin
            pack_data = {s3_sign, 31'h0};
            pack_uf   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_of    <= 1'b0;
            out_uf    <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            out_data  <= pack_data;
            out_of    <= pack_of;
            out_uf    <= pack_uf;
        end
    end
endmodule

// File: tb/tb_add_norm_round.sv
// Bench for add_norm_round. Directed vectors go through a scoreboard; it also checks
// latency, backpressure and reset in mid-stream.
module tb_add_norm_round;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [7:0]  in_e;
    logic        in_sign, in_sign_2;
    logic [26:0] in_m_1, in_m_2;
    logic        in_nan, in_inf, in_inf_sign;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_of, out_uf;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  e;
        logic        s1;
        logic        s2;
        logic [26:0] m1;
        logic [26:0] m2;
        logic        is_nan;
        logic        is_inf;
        logic        inf_sign;
        logic [33:0] res;   // {of, uf, data}
    } vec_t;

    vec_t        tbl[$];
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;

    add_norm_round dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_e(in_e), .in_sign(in_sign), .in_sign_2(in_sign_2),
        .in_m_1(in_m_1), .in_m_2(in_m_2), .in_nan(in_nan), .in_inf(in_inf),
        .in_inf_sign(in_inf_sign), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_of(out_of), .out_uf(out_uf)
    );

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) obs_q.push_back({out_of, out_uf, out_data});

    function automatic vec_t mk(input logic [7:0] e, input logic s1, input logic s2,
                                input logic [26:0] m1, input logic [26:0] m2,
                                input logic is_nan, input logic is_inf, input logic inf_sign,
                                input logic [33:0] res);
        vec_t v;
        v.e = e; v.s1 = s1; v.s2 = s2; v.m1 = m1; v.m2 = m2;
        v.is_nan = is_nan; v.is_inf = is_inf; v.inf_sign = inf_sign; v.res = res;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_e = v.e; in_sign = v.s1; in_sign_2 = v.s2; in_m_1 = v.m1; in_m_2 = v.m2;
        in_nan = v.is_nan; in_inf = v.is_inf; in_inf_sign = v.inf_sign;
    endtask

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int unsigned t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_accept: in_ready=%b want 1 within 50 cycles", in_ready);
        end else begin
            exp_q.push_back(v.res);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int unsigned t = 0; t < 100 && !ok; t++) begin
            @(posedge clk); #1;
            ok = (obs_q.size() >= exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(8'h0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0));
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", out_data); end
        checks++; if ({out_of, out_uf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {out_of, out_uf}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        bit ok;
        logic [33:0] e, o;
        out_ready = 1'b1;
        drive(tbl[0]);
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_accept: in_ready got %b want 1", in_ready); end
        exp_q.push_back(tbl[0].res);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== logic'(c == 3)) begin
                errors++; $display("FAIL latency_valid_%0d: got %b want %b", c + 1, out_valid, c == 3);
            end
        end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL latency_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL latency_result: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL latency_result: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_arith;
        bit ok;
        logic [33:0] e, o;
        out_ready = 1'b1;
        foreach (tbl[i]) send(tbl[i]);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL arith_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        for (int unsigned i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL arith_vec%0d: got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL arith_vec%0d: got %h want %h", i, o, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [32:0] held;
        logic [33:0] e, o;
        out_ready = 1'b1;
        fork
            begin
                for (int unsigned i = 0; i < 6; i++) send(tbl[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int unsigned c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b want 0", c, in_ready); end
                    if (c == 0) begin
                        held = {out_valid, out_data};
                        checks++;
                        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
                    end else begin
                        checks++;
                        if ({out_valid, out_data} !== held) begin
                            errors++; $display("FAIL stall_hold_%0d: got %h want %h", c, {out_valid, out_data}, held);
                        end
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        for (int unsigned i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_beat%0d: got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, o, e); end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra results want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_midstream;
        bit ok;
        logic [33:0] e, o;
        out_ready = 1'b1;
        for (int unsigned i = 6; i < 10; i++) send(tbl[i]);
        #2;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got %h want 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed_%0d: out_valid got %b want 0", c, out_valid); end
        end
        @(posedge clk); #1;
        send(tbl[14]);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL mid_after_reset: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL mid_after_reset: got %h want %h", o, e); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(8'h80, 0, 0, 27'h6000000, 27'h4000000, 0, 0, 0, {2'b00, 32'h40A00000}));
        tbl.push_back(mk(8'h7F, 0, 1, 27'h4000000, 27'h3FFFFFC, 0, 0, 0, {2'b00, 32'h33800000}));
        tbl.push_back(mk(8'h80, 0, 1, 27'h6000000, 27'h6000000, 0, 0, 0, {2'b00, 32'h00000000}));
        tbl.push_back(mk(8'h7F, 0, 0, 27'h4000000, 27'h0000004, 0, 0, 0, {2'b00, 32'h3F800000}));
        tbl.push_back(mk(8'h7F, 0, 0, 27'h4000000, 27'h0000006, 0, 0, 0, {2'b00, 32'h3F800001}));
        tbl.push_back(mk(8'hFE, 0, 0, 27'h7FFFFF8, 27'h7FFFFF8, 0, 0, 0, {2'b10, 32'h7F800000}));
        tbl.push_back(mk(8'h01, 0, 1, 27'h4000000, 27'h3FFFFF8, 0, 0, 0, {2'b01, 32'h00000000}));
        tbl.push_back(mk(8'h12, 0, 1, 27'h5555555, 27'h2AAAAAA, 1, 0, 0, {2'b00, 32'h7FC00000}));
        tbl.push_back(mk(8'hFE, 0, 0, 27'h7FFFFF8, 27'h7FFFFF8, 0, 1, 1, {2'b00, 32'hFF800000}));
        tbl.push_back(mk(8'h7F, 0, 0, 27'h7FFFFFC, 27'h0000000, 0, 0, 0, {2'b00, 32'h40000000}));
        tbl.push_back(mk(8'h80, 0, 1, 27'h4000000, 27'h6000000, 0, 0, 0, {2'b00, 32'hBF800000}));
        tbl.push_back(mk(8'h01, 0, 0, 27'h4000000, 27'h0000000, 0, 0, 0, {2'b00, 32'h00800000}));
        tbl.push_back(mk(8'hFE, 0, 0, 27'h4000000, 27'h0000000, 0, 0, 0, {2'b00, 32'h7F000000}));
        tbl.push_back(mk(8'hFE, 1, 1, 27'h7FFFFF8, 27'h7FFFFF8, 0, 0, 0, {2'b10, 32'hFF800000}));
        tbl.push_back(mk(8'h7F, 0, 0, 27'h4000005, 27'h4000004, 0, 0, 0, {2'b00, 32'h40000001}));

        test_reset();
        test_latency();
        test_arith();
        test_back_to_back();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_norm_round.md
# add_norm_round

Final pipelined stage of the single-precision floating-point add/sub datapath. It sits directly downstream of `aligner` and consumes its common exponent, signs and two 27-bit aligned, guarded mantissas. It performs the effective add/subtract, normalizes with a leading-zero shift and rounds to nearest-even. It then packs an IEEE-754 binary32 result behind a three-stage valid/ready pipeline.

## Interface
Parameters: none. Widths are fixed to binary32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset; one clock domain.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_e` in 8: common (larger) biased exponent from `aligner`.
- `in_sign` in 1: sign of operand 1 (the larger-exponent operand).
- `in_sign_2` in 1: effective sign of operand 2, with op already applied.
- `in_m_1`, `in_m_2` in 27 each: {hidden, 23 fraction, G, R, S}. The hidden bit is at bit 26.
- `in_nan` in 1: either operand NaN, or inf−inf. Forces the result to 0x7FC00000.
- `in_inf` in 1: result is infinity (and `in_nan` is low).
- `in_inf_sign` in 1: sign of that infinity.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 32: packed binary32 result.
- `out_of` out 1: overflow occurred, result is ±inf.
- `out_uf` out 1: underflow occurred, result flushed to ±0.

## Operation
- **Stage 1 (add/sub):**
  - If `in_sign == in_sign_2`, compute S = m1 + m2 (28 bits) with sign = `in_sign`.
  - Otherwise compute S = |m1 − m2|. Sign = `in_sign` if m1 ≥ m2, else `in_sign_2`.
  - Exact cancellation (S == 0) gives +0 with sign 0.
  - Exponent is carried as a 10-bit signed value E = {2'b00, `in_e`}.
- **Stage 2 (normalize):**
  - If S[27] = 1: shift right 1, OR the shifted-out bit into S[0] (sticky), and set E += 1.
  - Otherwise, count leading zeros L of S[26:0] (range 0..26), shift left by L, and set E −= L.
  - If S == 0, mark the result as zero and skip the shift.
- **Stage 3 (round/pack):** Let N[26:0] be the normalized value, with lsb = N[3], G = N[2], R = N[1], S = N[0].
  - Round up when G & (R | S | lsb).
  - The increment is applied to N[26:3] (24 bits). A carry out sets the mantissa to 1.0 and E += 1.
  - If E ≥ 255: output sign|0x7F800000 and set `out_of` = 1.
  - If E ≤ 0 and the result is non-zero: output sign|0x00000000 and set `out_uf` = 1. Subnormals are not produced (flush to zero).
  - Otherwise output {sign, E[7:0], N[25:3] after rounding}.
  - Special flags travel with the beat and override everything. `in_nan` produces 0x7FC00000. `in_inf` produces {`in_inf_sign`, 0x7F800000 bits}. When an override applies, `out_of` = `out_uf` = 0.

## Timing
- Latency is 3 cycles: a beat accepted at edge k is presented on `out_valid`/`out_data` after edge k+3, provided there is no stall.
- Throughput is 1 beat/cycle.
- Handshake:
  - A transfer occurs on an edge where valid & ready are both high.
  - `out_valid`/`out_data` hold stable until `out_ready`.
  - `out_data` does not depend combinationally on `out_ready`.
- Stall: define advance = !`out_valid` | `out_ready`.
  - All three stages and their valid bits shift only when advance is high.
  - `in_ready` = advance. It is combinational from `out_ready` and registered `out_valid` only.
- Bubbles: a stage with valid = 0 never blocks. While `out_valid` = 0, earlier stages keep filling.
- Simultaneous input accept and output drain in the same cycle is legal and loses no data.
- Reset (asynchronous assert, synchronous deassert):
  - All stage valid bits and `out_valid` = 0; `out_data` = 0x00000000; `out_of` = `out_uf` = 0.
  - `in_ready` = 1 after reset.
  - Reset mid-operation discards all in-flight beats. No partial result is emitted.

## Test plan
- 3 + 2: `in_e` = 0x80, m1 = 0x6000000, m2 = 0x4000000, both signs 0. Expect `out_data` = 0x40A00000 exactly 3 cycles after accept.
- 1 − 0.99999994: `in_e` = 0x7F, m1 = 0x4000000, m2 = 0x3FFFFFC, `in_sign_2` = 1. Expect 0x33800000, which exercises the full LZC shift. 3 − 3 with equal mantissas: expect 0x00000000.
- Rounding tie: `in_e` = 0x7F, m1 = 0x4000000, m2 = 0x0000004 (1 + 2^-24). Expect 0x3F800000 (ties-to-even). m2 = 0x0000006: expect 0x3F800001.
- Overflow: `in_e` = 0xFE, m1 = m2 = 0x7FFFFF8. Expect 0x7F800000 with `out_of` = 1. Underflow: `in_e` = 0x01, m1 = 0x4000000, m2 = 0x3FFFFF8, opposite signs. Expect 0x00000000 with `out_uf` = 1.
- Specials: `in_nan` = 1 gives 0x7FC00000. `in_inf` = 1 with `in_inf_sign` = 1 gives 0xFF800000. Both ignore the mantissa inputs.
- Backpressure: stream 6 back-to-back beats and hold `out_ready` = 0 for 4 cycles mid-stream.
  - `in_ready` must drop while stalled.
  - No beat may be lost, duplicated or reordered.
  - `out_data` must stay stable while stalled.
  - Asserting `rst_n` = 0 mid-stream must clear `out_valid` immediately.
